pipe_mux_n_to_1: RTL
====================

PIPE_MUX_N_TO_1 -- requirements
Module: pipe_mux_n_to_1

Interface
REQ-001 Parameter WORD_WIDTH, default 32: data word width in bits.
REQ-002 Parameter NUM_INPUTS, default 4, legal range 2..16: number of data inputs.
REQ-003 Parameter SEL_WIDTH, default $clog2(NUM_INPUTS): select width; SHALL be at least 1.
REQ-004 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port select, input, SEL_WIDTH: input index captured on accept.
REQ-007 Port inp, input, NUM_INPUTS*WORD_WIDTH: packed inputs; input k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-008 Port in_valid, input, 1: upstream offers select/inp this cycle.
REQ-009 Port in_ready, output, 1: block can accept this cycle.
REQ-010 Port flush, input, 1: discard held output.
REQ-011 Port out, output, WORD_WIDTH: registered selected word.
REQ-012 Port out_valid, output, 1: out holds an unconsumed word.
REQ-013 Port out_ready, input, 1: downstream consumes out this cycle.
REQ-014 Port sel_err, output, 1: sticky out-of-range-select flag.
REQ-015 Port err_count, output, 8: count of out-of-range accepts.

Function
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-017 Accept SHALL occur when in_valid && in_ready && !flush; out SHALL then be inp word[select] on the next edge, with out_valid = 1 (latency 1).
REQ-018 On out_valid && out_ready without accept, out_valid SHALL clear next edge; out SHALL keep its last value.
REQ-019 Simultaneous consume and accept SHALL load the new word with out_valid staying 1 (no bubble, full throughput).
REQ-020 While out_valid && !out_ready, out SHALL remain stable and in_ready SHALL be 0.
REQ-021 flush SHALL clear out_valid next edge, override accept, and leave out unchanged.
REQ-022 select >= NUM_INPUTS on accept SHALL load out = 0 with out_valid = 1.
REQ-023 select SHALL be sampled only on accept; changes at other times SHALL have no effect.

Reset
REQ-024 rst_n low SHALL immediately force out = 0, out_valid = 0, sel_err = 0, err_count = 0, regardless of clk.
REQ-025 Reset mid-transfer SHALL discard the held word; first accept after release SHALL behave as from idle.

Configuration
REQ-026 With PIPE_MUX_SEL_CHECK_EN defined: on each accept with select >= NUM_INPUTS, sel_err SHALL set (sticky until reset) and err_count SHALL increment, saturating at 255.
REQ-027 Without PIPE_MUX_SEL_CHECK_EN: sel_err and err_count SHALL be constant 0 and no check/counter logic SHALL be synthesised; REQ-022 still applies.

Structure
REQ-028 Shared package mux_pkg SHALL hold default WORD_WIDTH, NUM_INPUTS, the 8-bit error-count type and its saturation constant.
REQ-029 Combinational selection SHALL be a sub-module mux_n_to_1_core (parameters WORD_WIDTH, NUM_INPUTS; out-of-range yields 0); pipe_mux_n_to_1 SHALL hold the register, handshake and error logic.

Verification
REQ-030 Reset: rst_n low mid-cycle with out_valid = 1 -> out = 0, out_valid = 0 immediately, in_ready = 1.
REQ-031 Streaming: NUM_INPUTS = 4, inp = {D,C,B,A} = 0xDDDD_DDDD..0xAAAA_AAAA, out_ready = 1, select 0,1,2,3 on consecutive cycles -> out = A,B,C,D on the following cycles, out_valid continuously 1.
REQ-032 Backpressure: accept select = 2, out_ready = 0 for 3 cycles -> out = C stable, in_ready = 0; new in_valid ignored until out_ready = 1.
REQ-033 Flush: flush = 1 with in_valid = 1, select = 1 -> out_valid = 0 next cycle, out unchanged.
REQ-034 Out-of-range, NUM_INPUTS = 3, macro defined: accept select = 3 -> out = 0, out_valid = 1, sel_err = 1, err_count = 1; 300 such accepts -> err_count = 255; macro undefined -> sel_err = 0, err_count = 0.
REQ-035 Width sweep: WORD_WIDTH = 8, NUM_INPUTS = 16, random select/inp with random out_ready -> scoreboard matches inp[select] in order, no loss or duplication.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and error-count types for the pipelined N:1 mux.
package mux_pkg;

  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_NUM_INPUTS = 4;

  typedef logic [7:0] err_cnt_t;
  localparam err_cnt_t ERR_CNT_MAX = 8'hFF;

  // Saturating increment: holds at ERR_CNT_MAX instead of wrapping to zero.
  function automatic err_cnt_t err_cnt_inc(input err_cnt_t c);
    return (c == ERR_CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/mux_n_to_1_core.sv
// Combinational N:1 word select. An out-of-range select matches no input
// and therefore yields an all-zero word.
module mux_n_to_1_core
  import mux_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [SEL_WIDTH-1:0]             sel_i,
  input  logic [NUM_INPUTS*WORD_WIDTH-1:0] data_i,
  output logic [WORD_WIDTH-1:0]            data_o
);

  logic [NUM_INPUTS-1:0][WORD_WIDTH-1:0] masked;

  // Each input is gated by its own decode; at most one survives.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_in
    assign masked[k] = (sel_i == SEL_WIDTH'(k)) ? data_i[k*WORD_WIDTH +: WORD_WIDTH] : '0;
  end

  // OR-reduce the gated words into the selected one.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_INPUTS; k++) data_o = data_o | masked[k];
  end

endmodule

// File: rtl/pipe_mux_n_to_1.sv
// Registered N:1 mux with valid/ready handshake and flush.
// Optional select range checking (sticky flag + saturating counter) is
// built only when PIPE_MUX_SEL_CHECK_EN is defined.
module pipe_mux_n_to_1
  import mux_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int SEL_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SEL_WIDTH-1:0]             select,
  input  logic [NUM_INPUTS*WORD_WIDTH-1:0] inp,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  output logic [WORD_WIDTH-1:0]            out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             sel_err,
  output err_cnt_t                         err_count
);

  logic [WORD_WIDTH-1:0] sel_word;
  logic [WORD_WIDTH-1:0] out_q;
  logic                  valid_q, valid_d;
  logic                  accept;

  mux_n_to_1_core #(
    .WORD_WIDTH(WORD_WIDTH),
    .NUM_INPUTS(NUM_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_core (
    .sel_i (select),
    .data_i(inp),
    .data_o(sel_word)
  );

  // The slot is free when empty or being drained this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Flush wins over accept; a consume without a refill empties the slot.
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  // Output word only changes on accept, so it holds across stalls and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) out_q <= sel_word;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

`ifdef PIPE_MUX_SEL_CHECK_EN
  logic     sel_err_q;
  err_cnt_t err_cnt_q;
  logic     sel_oor;

  assign sel_oor = int'(select) >= NUM_INPUTS;

  // Sticky flag and saturating count of accepts with an out-of-range select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (accept && sel_oor) begin
      sel_err_q <= 1'b1;
      err_cnt_q <= err_cnt_inc(err_cnt_q);
    end
  end

  assign sel_err   = sel_err_q;
  assign err_count = err_cnt_q;
`else
  assign sel_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule
